// File: rtl/control_sequencer.sv
// control_sequencer: Moore control FSM driving the data_path fetch/decode/
// execute/memory sequence, with a bounded memory-wait timeout, a sticky
// fault state and a retired-instruction counter.
module control_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IR_Out,
  input  logic        MFC,
  input  logic [3:0]  SR_Flags,
  output logic        MAR_EN,
  output logic        MDR_EN,
  output logic        IR_EN,
  output logic        RF_RW,
  output logic        SR_EN,
  output logic        MFA,
  output logic        RW_RAM,
  output logic [1:0]  DataSize,
  output logic [3:0]  State,
  output logic        Fault,
  output logic [7:0]  Retired
);

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_FETCH_ADDR = 4'd1,
    S_FETCH_MEM  = 4'd2,
    S_FETCH_IR   = 4'd3,
    S_DECODE     = 4'd4,
    S_EXEC_ALU   = 4'd5,
    S_MEM_ADDR   = 4'd6,
    S_MEM_ACCESS = 4'd7,
    S_MEM_WB     = 4'd8,
    S_FAULT      = 4'd9
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_wait;
  logic [7:0]  r_retired;
  logic        w_cond;
  logic        w_timeout;
  logic        w_retire;
  logic        w_in_wait;
  logic        w_n, w_z, w_c, w_v;
  logic        w_unused;

  assign w_n = SR_Flags[3];
  assign w_z = SR_Flags[2];
  assign w_c = SR_Flags[1];
  assign w_v = SR_Flags[0];

  // IR fields this sequencer does not decode
  assign w_unused = ^{IR_Out[25:23], IR_Out[21], IR_Out[19:0]};

  assign w_in_wait = (r_state == S_FETCH_MEM) || (r_state == S_MEM_ACCESS);
  // r_wait == 15 means this is the 16th consecutive MFC=0 cycle
  assign w_timeout = (r_wait == 4'hF);

  // ARM condition-code evaluation of IR_Out[31:28] against {N,Z,C,V}
  always_comb begin
    w_cond = 1'b0;
    case (IR_Out[31:28])
      4'b0000: w_cond = w_z;
      4'b0001: w_cond = !w_z;
      4'b0010: w_cond = w_c;
      4'b0011: w_cond = !w_c;
      4'b0100: w_cond = w_n;
      4'b0101: w_cond = !w_n;
      4'b0110: w_cond = w_v;
      4'b0111: w_cond = !w_v;
      4'b1000: w_cond = w_c && !w_z;
      4'b1001: w_cond = !w_c || w_z;
      4'b1010: w_cond = (w_n == w_v);
      4'b1011: w_cond = (w_n != w_v);
      4'b1100: w_cond = !w_z && (w_n == w_v);
      4'b1101: w_cond = w_z || (w_n != w_v);
      4'b1110: w_cond = 1'b1;
      default: w_cond = 1'b0;
    endcase
  end

  // Next-state selection; unused encodings fall into FAULT
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:       w_next = S_FETCH_ADDR;
      S_FETCH_ADDR: w_next = S_FETCH_MEM;
      S_FETCH_MEM: begin
        if (MFC)            w_next = S_FETCH_IR;
        else if (w_timeout) w_next = S_FAULT;
      end
      S_FETCH_IR:   w_next = S_DECODE;
      S_DECODE: begin
        if (!w_cond) w_next = S_FETCH_ADDR;
        else begin
          case (IR_Out[27:26])
            2'b01:   w_next = S_MEM_ADDR;
            2'b11:   w_next = S_FAULT;
            default: w_next = S_EXEC_ALU;
          endcase
        end
      end
      S_EXEC_ALU:   w_next = S_FETCH_ADDR;
      S_MEM_ADDR:   w_next = S_MEM_ACCESS;
      S_MEM_ACCESS: begin
        if (MFC)            w_next = IR_Out[20] ? S_MEM_WB : S_FETCH_ADDR;
        else if (w_timeout) w_next = S_FAULT;
      end
      S_MEM_WB:     w_next = S_FETCH_ADDR;
      S_FAULT:      w_next = S_FAULT;
      default:      w_next = S_FAULT;
    endcase
  end

  // An instruction retires whenever control returns to FETCH_ADDR from an
  // executing state, including condition-failed instructions out of DECODE
  assign w_retire = (w_next == S_FETCH_ADDR) &&
                    ((r_state == S_DECODE)     || (r_state == S_EXEC_ALU) ||
                     (r_state == S_MEM_ACCESS) || (r_state == S_MEM_WB));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Memory-wait counter: counts MFC=0 cycles in a wait state, zero elsewhere,
  // so it is always clear on entry to FETCH_MEM/MEM_ACCESS
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 r_wait <= '0;
    else if (w_in_wait && !MFC) r_wait <= r_wait + 4'd1;
    else                       r_wait <= '0;
  end

  // Retired-instruction counter, wraps naturally at 8 bits
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         r_retired <= '0;
    else if (w_retire) r_retired <= r_retired + 8'd1;
  end

  // Moore output decode (MEM_ACCESS also looks at IR_Out and MFC)
  always_comb begin
    MAR_EN   = 1'b0;
    MDR_EN   = 1'b0;
    IR_EN    = 1'b0;
    RF_RW    = 1'b0;
    SR_EN    = 1'b0;
    MFA      = 1'b0;
    RW_RAM   = 1'b0;
    DataSize = 2'b00;
    Fault    = 1'b0;
    case (r_state)
      S_FETCH_ADDR: MAR_EN = 1'b1;
      S_FETCH_MEM: begin
        MFA      = 1'b1;
        RW_RAM   = 1'b1;
        DataSize = 2'b10;
      end
      S_FETCH_IR:   IR_EN = 1'b1;
      S_EXEC_ALU: begin
        RF_RW = 1'b1;
        SR_EN = (IR_Out[27:26] == 2'b00) ? IR_Out[20] : 1'b0;
      end
      S_MEM_ADDR:   MAR_EN = 1'b1;
      S_MEM_ACCESS: begin
        MFA      = 1'b1;
        RW_RAM   = IR_Out[20];
        DataSize = IR_Out[22] ? 2'b00 : 2'b10;
        MDR_EN   = IR_Out[20] & MFC;
      end
      S_MEM_WB:     RF_RW = 1'b1;
      S_FAULT:      Fault = 1'b1;
      default: ;
    endcase
  end

  assign State   = r_state;
  assign Retired = r_retired;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: the driver pushes hand-computed
// per-cycle expectations; the monitor pops and compares on each falling edge.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] IR_Out;
  logic        MFC;
  logic [3:0]  SR_Flags;
  logic        MAR_EN, MDR_EN, IR_EN, RF_RW, SR_EN, MFA, RW_RAM, Fault;
  logic [1:0]  DataSize;
  logic [3:0]  State;
  logic [7:0]  Retired;

  control_sequencer dut (
    .clk(clk), .reset(reset), .IR_Out(IR_Out), .MFC(MFC), .SR_Flags(SR_Flags),
    .MAR_EN(MAR_EN), .MDR_EN(MDR_EN), .IR_EN(IR_EN), .RF_RW(RF_RW),
    .SR_EN(SR_EN), .MFA(MFA), .RW_RAM(RW_RAM), .DataSize(DataSize),
    .State(State), .Fault(Fault), .Retired(Retired)
  );

  always #5 clk = ~clk;

  // ctl bit order: {MAR_EN,MDR_EN,IR_EN,RF_RW,SR_EN,MFA,RW_RAM,DataSize[1:0],Fault}
  localparam logic [9:0] C_NONE  = 10'b0000000000;
  localparam logic [9:0] C_MAR   = 10'b1000000000;
  localparam logic [9:0] C_FMEM  = 10'b0000011100;
  localparam logic [9:0] C_IR    = 10'b0010000000;
  localparam logic [9:0] C_ALUS  = 10'b0001100000;
  localparam logic [9:0] C_RF    = 10'b0001000000;
  localparam logic [9:0] C_LD    = 10'b0000011000;
  localparam logic [9:0] C_LDM   = 10'b0100011000;
  localparam logic [9:0] C_ST    = 10'b0000010100;
  localparam logic [9:0] C_FAULT = 10'b0000000001;

  localparam logic [31:0] IR_ALU  = 32'hE0910002;
  localparam logic [31:0] IR_EQB  = 32'h0A000000;
  localparam logic [31:0] IR_LDRB = 32'hE5D10000;
  localparam logic [31:0] IR_STR  = 32'hE5810000;
  localparam logic [31:0] IR_BAD  = 32'hEC000000;

  typedef struct {
    logic [3:0] st;
    logic [9:0] ctl;
    logic [7:0] ret;
    int         id;
  } exp_t;

  exp_t q[$];
  int   n_id   = 0;
  int   checks = 0;
  int   errors = 0;

  // One clock of stimulus: drive inputs just after the edge and record what
  // the outputs must show for the rest of that cycle
  task automatic cyc(input logic [31:0] ir, input logic mfc,
                     input logic [3:0] st, input logic [9:0] ctl,
                     input logic [7:0] ret);
    @(posedge clk);
    #1;
    IR_Out = ir;
    MFC    = mfc;
    q.push_back('{st: st, ctl: ctl, ret: ret, id: n_id});
    n_id++;
  endtask

  // Reset set or released between edges; state must read IDLE either way
  task automatic rst_cyc(input logic r);
    @(posedge clk);
    #1;
    reset = r;
    MFC   = 1'b0;
    q.push_back('{st: 4'd0, ctl: C_NONE, ret: 8'd0, id: n_id});
    n_id++;
  endtask

  // Monitor: compares every presented cycle against the scoreboard head
  initial begin
    exp_t       e;
    logic [9:0] act;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e   = q.pop_front();
        act = {MAR_EN, MDR_EN, IR_EN, RF_RW, SR_EN, MFA, RW_RAM, DataSize, Fault};
        checks++;
        if (State !== e.st || act !== e.ctl || Retired !== e.ret) begin
          errors++;
          $display("FAIL cycle%0d state/ctl/retired got %0d/%b/%0d expected %0d/%b/%0d",
                   e.id, State, act, Retired, e.st, e.ctl, e.ret);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    IR_Out   = IR_ALU;
    MFC      = 1'b0;
    SR_Flags = 4'b0000;

    rst_cyc(1'b1);
    rst_cyc(1'b0);

    // ALU path, MFC on the third FETCH_MEM cycle
    cyc(IR_ALU, 0, 4'd1, C_MAR,  8'd0);
    cyc(IR_ALU, 0, 4'd2, C_FMEM, 8'd0);
    cyc(IR_ALU, 0, 4'd2, C_FMEM, 8'd0);
    cyc(IR_ALU, 1, 4'd2, C_FMEM, 8'd0);
    cyc(IR_ALU, 0, 4'd3, C_IR,   8'd0);
    cyc(IR_ALU, 0, 4'd4, C_NONE, 8'd0);
    cyc(IR_ALU, 0, 4'd5, C_ALUS, 8'd0);
    cyc(IR_ALU, 0, 4'd1, C_MAR,  8'd1);

    // Condition fails (EQ, Z=0); MFC pulses outside wait states are ignored
    cyc(IR_EQB, 1, 4'd2, C_FMEM, 8'd1);
    cyc(IR_EQB, 1, 4'd3, C_IR,   8'd1);
    cyc(IR_EQB, 1, 4'd4, C_NONE, 8'd1);
    cyc(IR_EQB, 0, 4'd1, C_MAR,  8'd2);

    // LDRB: byte load through MEM_WB
    cyc(IR_LDRB, 1, 4'd2, C_FMEM, 8'd2);
    cyc(IR_LDRB, 0, 4'd3, C_IR,   8'd2);
    cyc(IR_LDRB, 0, 4'd4, C_NONE, 8'd2);
    cyc(IR_LDRB, 0, 4'd6, C_MAR,  8'd2);
    cyc(IR_LDRB, 0, 4'd7, C_LD,   8'd2);
    cyc(IR_LDRB, 1, 4'd7, C_LDM,  8'd2);
    cyc(IR_LDRB, 0, 4'd8, C_RF,   8'd2);
    cyc(IR_LDRB, 0, 4'd1, C_MAR,  8'd3);

    // STR: word store skips MEM_WB, no MDR load even with MFC
    cyc(IR_STR, 1, 4'd2, C_FMEM, 8'd3);
    cyc(IR_STR, 0, 4'd3, C_IR,   8'd3);
    cyc(IR_STR, 0, 4'd4, C_NONE, 8'd3);
    cyc(IR_STR, 0, 4'd6, C_MAR,  8'd3);
    cyc(IR_STR, 0, 4'd7, C_ST,   8'd3);
    cyc(IR_STR, 1, 4'd7, C_ST,   8'd3);
    cyc(IR_STR, 0, 4'd1, C_MAR,  8'd4);

    // MFC arriving on the 16th wait cycle wins over the timeout
    for (int i = 0; i < 15; i++) cyc(IR_ALU, 0, 4'd2, C_FMEM, 8'd4);
    cyc(IR_ALU, 1, 4'd2, C_FMEM, 8'd4);
    cyc(IR_ALU, 0, 4'd3, C_IR,   8'd4);
    cyc(IR_ALU, 0, 4'd4, C_NONE, 8'd4);
    cyc(IR_ALU, 0, 4'd5, C_ALUS, 8'd4);
    cyc(IR_ALU, 0, 4'd1, C_MAR,  8'd5);

    // 16 MFC=0 cycles in FETCH_MEM end in FAULT; later MFC does nothing
    for (int i = 0; i < 16; i++) cyc(IR_ALU, 0, 4'd2, C_FMEM, 8'd5);
    cyc(IR_ALU, 1, 4'd9, C_FAULT, 8'd5);
    cyc(IR_ALU, 1, 4'd9, C_FAULT, 8'd5);
    cyc(IR_ALU, 0, 4'd9, C_FAULT, 8'd5);
    rst_cyc(1'b1);
    rst_cyc(1'b0);

    // EQ true (Z=1) on a branch-class opcode: EXEC_ALU with SR_EN forced 0
    SR_Flags = 4'b0100;
    cyc(IR_EQB, 0, 4'd1, C_MAR,  8'd0);
    cyc(IR_EQB, 1, 4'd2, C_FMEM, 8'd0);
    cyc(IR_EQB, 0, 4'd3, C_IR,   8'd0);
    cyc(IR_EQB, 0, 4'd4, C_NONE, 8'd0);
    cyc(IR_EQB, 0, 4'd5, C_RF,   8'd0);
    cyc(IR_EQB, 0, 4'd1, C_MAR,  8'd1);

    // Reset raised mid MEM_ACCESS, between edges
    cyc(IR_LDRB, 1, 4'd2, C_FMEM, 8'd1);
    cyc(IR_LDRB, 0, 4'd3, C_IR,   8'd1);
    cyc(IR_LDRB, 0, 4'd4, C_NONE, 8'd1);
    cyc(IR_LDRB, 0, 4'd6, C_MAR,  8'd1);
    cyc(IR_LDRB, 0, 4'd7, C_LD,   8'd1);
    rst_cyc(1'b1);
    rst_cyc(1'b0);

    // Opcode class 11 decodes to FAULT
    cyc(IR_BAD, 0, 4'd1, C_MAR,   8'd0);
    cyc(IR_BAD, 1, 4'd2, C_FMEM,  8'd0);
    cyc(IR_BAD, 0, 4'd3, C_IR,    8'd0);
    cyc(IR_BAD, 0, 4'd4, C_NONE,  8'd0);
    cyc(IR_BAD, 0, 4'd9, C_FAULT, 8'd0);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain %0d expectations left, required 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL: clk  input  1  single system clock; all state changes on rising edge.
REQ-002 SHALL: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL: IR_Out  input  32  current instruction register contents from data_path.
REQ-004 SHALL: MFC  input  1  memory function complete, sampled only in memory-wait states.
REQ-005 SHALL: SR_Flags  input  4  status flags {N,Z,C,V}, bit 3 = N.
REQ-006 SHALL: MAR_EN, MDR_EN, IR_EN, RF_RW, SR_EN, MFA  output  1 each  data_path load/strobe controls.
REQ-007 SHALL: RW_RAM  output  1  memory direction, 1 = read, 0 = write.
REQ-008 SHALL: DataSize  output  2  2'b10 = word, 2'b00 = byte.
REQ-009 SHALL: State  output  4  current state encoding, for debug.
REQ-010 SHALL: Fault  output  1  sticky error indicator.
REQ-011 SHALL: Retired  output  8  count of instructions completed, wraps 255 -> 0.

Function
REQ-012 SHALL: state encoding: 0 IDLE, 1 FETCH_ADDR, 2 FETCH_MEM, 3 FETCH_IR, 4 DECODE, 5 EXEC_ALU, 6 MEM_ADDR, 7 MEM_ACCESS, 8 MEM_WB, 9 FAULT; codes 10-15 SHALL go to FAULT.
REQ-013 SHALL: outputs are a Moore decode of State (plus IR_Out/MFC where stated); outputs not listed for a state are 0.
REQ-014 SHALL: IDLE -> FETCH_ADDR unconditionally.
REQ-015 SHALL: FETCH_ADDR: MAR_EN=1; next FETCH_MEM.
REQ-016 SHALL: FETCH_MEM: MFA=1, RW_RAM=1, DataSize=2'b10; MFC=1 -> FETCH_IR, else stay.
REQ-017 SHALL: FETCH_IR: IR_EN=1; next DECODE.
REQ-018 SHALL: DECODE: evaluate cond=IR_Out[31:28] against SR_Flags per ARM rules (EQ..LE, 1110 AL always true, 1111 always false).
REQ-019 SHALL: DECODE, cond false -> FETCH_ADDR; true and IR_Out[27:26]=00 or 10 -> EXEC_ALU; 01 -> MEM_ADDR; 11 -> FAULT.
REQ-020 SHALL: EXEC_ALU: RF_RW=1; SR_EN=IR_Out[20] when IR_Out[27:26]=00, else 0; next FETCH_ADDR.
REQ-021 SHALL: MEM_ADDR: MAR_EN=1; next MEM_ACCESS.
REQ-022 SHALL: MEM_ACCESS: MFA=1, RW_RAM=IR_Out[20], DataSize=IR_Out[22]?2'b00:2'b10, MDR_EN=IR_Out[20]&MFC.
REQ-023 SHALL: MEM_ACCESS on MFC=1: load (IR_Out[20]=1) -> MEM_WB, store -> FETCH_ADDR; MFC=0 -> stay.
REQ-024 SHALL: MEM_WB: RF_RW=1; next FETCH_ADDR.
REQ-025 SHALL: wait counter (4 bit) clears on entry to FETCH_MEM/MEM_ACCESS, increments each cycle MFC=0 there; 16th consecutive MFC=0 cycle -> FAULT instead of staying.
REQ-026 SHALL: MFC=1 in the same cycle as the 16th wait SHALL take priority (normal transition, no fault).
REQ-027 SHALL: FAULT: Fault=1, all strobes 0, MFA=0, remains until reset.
REQ-028 SHALL: Retired increments by 1 on every transition into FETCH_ADDR from DECODE, EXEC_ALU, MEM_ACCESS or MEM_WB (condition-failed instructions count).
REQ-029 SHALL: MFC outside FETCH_MEM/MEM_ACCESS is ignored.

Reset
REQ-030 SHALL: reset=1 asynchronously forces State=IDLE, wait counter=0, Retired=0, Fault=0, all outputs 0 (RW_RAM=0, DataSize=2'b00), regardless of current state, including mid memory wait.
REQ-031 SHALL: first rising edge after reset deasserts moves IDLE -> FETCH_ADDR.

Verification
REQ-032 SHALL: ALU path: IR_Out=32'hE0910002, MFC=1 on 3rd FETCH_MEM cycle -> State 1,2,2,2,3,4,5,1; SR_EN=1 and RF_RW=1 only in state 5; Retired 0->1.
REQ-033 SHALL: cond fail: IR_Out=32'h0A000000, SR_Flags=4'b0000 -> DECODE goes to 1; RF_RW never 1; Retired increments.
REQ-034 SHALL: LDRB: IR_Out=32'hE5D10000 -> state 7 shows RW_RAM=1, DataSize=00, MDR_EN=1 only in the MFC cycle; then state 8 RF_RW=1; then 1.
REQ-035 SHALL: STR: IR_Out=32'hE5810000 -> state 7 RW_RAM=0, DataSize=10, MDR_EN=0; MFC=1 -> state 1, no MEM_WB.
REQ-036 SHALL: timeout: MFC held 0 in FETCH_MEM -> 16 cycles later State=9, Fault=1, MFA=0; MFC=1 afterwards has no effect; reset clears.
REQ-037 SHALL: reset asserted mid-state 7 (asynchronous, between edges) -> outputs 0 and State=0 immediately; Retired=0.
